// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider: out = ina / inb, with rounding and saturation.
// Latency WN+2 cycles (one restoring step per clock). A result is held until out_ready; nothing new is accepted until then.
module fxp_div_seq #(
    parameter int A_width_int       = 8,
    parameter int A_width_frac      = 8,
    parameter int B_width_int       = 8,
    parameter int B_width_frac      = 8,
    parameter int output_width_int  = 8,
    parameter int output_width_frac = 8,
    parameter int ROUND             = 1
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [A_width_int+A_width_frac-1:0]          ina,
    input  logic [B_width_int+B_width_frac-1:0]          inb,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [output_width_int+output_width_frac-1:0] out,
    output logic                                         overflow,
    output logic                                         divzero
);
    localparam int WA   = A_width_int + A_width_frac;
    localparam int WB   = B_width_int + B_width_frac;
    localparam int WO   = output_width_int + output_width_frac;
    localparam int S    = output_width_frac + B_width_frac - A_width_frac + 1;
    localparam int WN   = WA + S;
    localparam int CW   = ((WN > WO) ? WN : WO) + 1;
    localparam int CNTW = $clog2(WN + 1);

    localparam logic [CW-1:0] LIM_NEG = CW'(1) << (WO - 1);
    localparam logic [CW-1:0] LIM_POS = LIM_NEG - CW'(1);
    localparam logic [WO-1:0] MAX_POS = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] MIN_NEG = {1'b1, {(WO-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, FIN, DONE} state_t;
    state_t state, state_nxt;

    logic            sign_q, sign_a, zero_b;
    logic [WN-1:0]   num, quo;
    logic [WB-1:0]   dvs;
    logic [WB:0]     rem;
    logic [CNTW-1:0] cnt;
    logic [WO-1:0]   out_r;
    logic            ovf_r, dz_r;

    logic            accept;
    logic [WA-1:0]   abs_a;
    logic [WB-1:0]   abs_b;
    logic [WB+1:0]   r_sh;
    logic [WB:0]     r_diff;
    logic            ge;
    logic [CW-1:0]   mag;
    logic [WO-1:0]   fin_out;
    logic            fin_ovf;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign out       = out_r;
    assign overflow  = ovf_r;
    assign divzero   = dz_r;

    // The most-negative operand maps to 100..0, which is its correct unsigned magnitude.
    assign abs_a = ina[WA-1] ? (~ina + 1'b1) : ina;
    assign abs_b = inb[WB-1] ? (~inb + 1'b1) : inb;

    assign r_sh   = {rem, num[WN-1]};
    assign ge     = (r_sh >= {2'b00, dvs});
    assign r_diff = r_sh[WB:0] - {1'b0, dvs};

    // Quotient LSB sits half an output LSB below the result and acts as the round bit.
    assign mag = CW'(quo[WN-1:1]) + CW'((ROUND != 0) && quo[0]);

    always_comb begin
        fin_out = '0;
        fin_ovf = 1'b0;
        if (zero_b) begin
            fin_out = sign_a ? MIN_NEG : MAX_POS;
            fin_ovf = 1'b1;
        end else if (!sign_q) begin
            if (mag > LIM_POS) begin
                fin_out = MAX_POS;
                fin_ovf = 1'b1;
            end else begin
                fin_out = mag[WO-1:0];
            end
        end else begin
            if (mag > LIM_NEG) begin
                fin_out = MIN_NEG;
                fin_ovf = 1'b1;
            end else begin
                fin_out = ~mag[WO-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = DIV;
            DIV:     if (cnt == CNTW'(1)) state_nxt = FIN;
            FIN:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sign_q <= 1'b0;
            sign_a <= 1'b0;
            zero_b <= 1'b0;
            num    <= '0;
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            cnt    <= '0;
            out_r  <= '0;
            ovf_r  <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sign_q <= ina[WA-1] ^ inb[WB-1];
                    sign_a <= ina[WA-1];
                    zero_b <= (inb == '0);
                    num    <= {abs_a, {S{1'b0}}};
                    dvs    <= abs_b;
                    rem    <= '0;
                    quo    <= '0;
                    cnt    <= CNTW'(WN);
                end
                DIV: begin
                    rem <= ge ? r_diff : r_sh[WB:0];
                    quo <= {quo[WN-2:0], ge};
                    num <= {num[WN-2:0], 1'b0};
                    cnt <= cnt - CNTW'(1);
                end
                FIN: begin
                    out_r <= fin_out;
                    ovf_r <= fin_ovf;
                    dz_r  <= zero_b;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed bench for fxp_div_seq: a rounding and a truncating instance share one stimulus stream.
module tb_fxp_div_seq;
    logic        clk = 1'b0;
    logic        rstn, in_valid, out_ready;
    logic [15:0] ina, inb;
    logic        in_ready, out_valid, overflow, divzero;
    logic [15:0] out;
    logic        in_ready_t, out_valid_t, overflow_t, divzero_t;
    logic [15:0] out_t;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fxp_div_seq #(.ROUND(1)) u_rnd (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .ina(ina), .inb(inb), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .overflow(overflow), .divzero(divzero)
    );

    fxp_div_seq #(.ROUND(0)) u_trunc (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_t),
        .ina(ina), .inb(inb), .out_valid(out_valid_t), .out_ready(out_ready),
        .out(out_t), .overflow(overflow_t), .divzero(divzero_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input string tag, input logic [15:0] a, input logic [15:0] b);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        ina      = a;
        inb      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ina      = 16'hA5A5;
        inb      = 16'h5A5A;
    endtask

    // Accept edge is edge 0; out_valid must first be seen after edge WN+1 = 26.
    task automatic wait_res(input string tag);
        int n = 0;
        int rdy_hi = 0;
        while (!out_valid && n < 60) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_edges"}, 32'(n), 32'd26);
        chk({tag, "_busy_rdy"}, 32'(rdy_hi), 32'd0);
        chk({tag, "_valid_t"}, 32'(out_valid_t), 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [15:0] er, input logic [15:0] et,
                             input logic eo, input logic ed);
        chk({tag, "_out"}, 32'(out), 32'(er));
        chk({tag, "_out_t"}, 32'(out_t), 32'(et));
        chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
        chk({tag, "_ovf_t"}, 32'(overflow_t), 32'(eo));
        chk({tag, "_dz"}, 32'(divzero), 32'(ed));
        chk({tag, "_dz_t"}, 32'(divzero_t), 32'(ed));
    endtask

    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [15:0] et, input logic eo, input logic ed);
        start(tag, a, b);
        wait_res(tag);
        check_res(tag, er, et, eo, ed);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vld_hi;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ina       = 16'h0000;
        inb       = 16'h0000;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_dz", 32'(divzero), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        run("div_3_2",   16'h0300, 16'h0200, 16'h0180, 16'h0180, 1'b0, 1'b0);
        run("rnd_pos",   16'h0001, 16'h0200, 16'h0001, 16'h0000, 1'b0, 1'b0);
        run("rnd_neg",   16'hFFFF, 16'h0200, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        run("m1_div_3",  16'hFF00, 16'h0300, 16'hFFAB, 16'hFFAB, 1'b0, 1'b0);
        run("sat_pos",   16'h6400, 16'h0040, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        run("sat_neg",   16'h9C00, 16'h0040, 16'h8000, 16'h8000, 1'b1, 1'b0);
        run("min_div_1", 16'h8000, 16'h0100, 16'h8000, 16'h8000, 1'b0, 1'b0);
        run("min_div_m1",16'h8000, 16'hFF00, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
        run("dz_pos",    16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
        run("dz_neg",    16'hFF00, 16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1);
        run("dz_zero",   16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: result must be held while out_ready stays low.
        out_ready = 1'b0;
        start("bp", 16'hFF00, 16'h0300);
        wait_res("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
            chk("bp_hold_out", 32'(out), 32'h0000FFAB);
            chk("bp_hold_ovf", 32'(overflow), 32'd0);
            chk("bp_hold_dz", 32'(divzero), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        run("bp_next", 16'h0300, 16'h0200, 16'h0180, 16'h0180, 1'b0, 1'b0);

        // Leave nonzero outputs behind so the reset clear is visible.
        run("dz_pre_rst", 16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
        start("rst_mid", 16'h0300, 16'h0200);
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_dz", 32'(divzero), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        vld_hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || out_valid_t) vld_hi++;
            @(posedge clk); #1;
        end
        chk("postrst_valid_cnt", 32'(vld_hi), 32'd0);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        run("postrst_3_2", 16'h0300, 16'h0200, 16'h0180, 16'h0180, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
